// File: rtl/operand_fetch_pkg.sv
// Shared datapath definitions: default widths, shift codes and a reference
// shifter helper used by the stage that consumes operand B and the shift code.
package operand_fetch_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  typedef enum logic [1:0] {
    SHIFT_PASS   = 2'b00,
    SHIFT_LEFT   = 2'b01,
    SHIFT_LRIGHT = 2'b10,
    SHIFT_ARIGHT = 2'b11
  } shift_e;

  // Single-position shift of a default-width word by the given shift code
  function automatic logic [DATA_W_DEF-1:0] shiftApply(
    input logic [DATA_W_DEF-1:0] data,
    input logic [1:0]            code
  );
    logic [DATA_W_DEF-1:0] res;
    res = data;
    case (code)
      SHIFT_LEFT:   res = {data[DATA_W_DEF-2:0], 1'b0};
      SHIFT_LRIGHT: res = {1'b0, data[DATA_W_DEF-1:1]};
      SHIFT_ARIGHT: res = {data[DATA_W_DEF-1], data[DATA_W_DEF-1:1]};
      default:      res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// Register array with one write port, two asynchronous read ports and an
// asynchronous clear of every word.
module operand_fetch_regfile
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_num_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [REG_AW-1:0] rd_num_a_i,
  input  logic [REG_AW-1:0] rd_num_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Store write data into the addressed word; reset clears the whole array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_num_i] <= wr_data_i;
    end
  end

  assign rd_data_a_o = regs_q[rd_num_a_i];
  assign rd_data_b_o = regs_q[rd_num_b_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads an operand pair from the register file (with
// same-edge write bypass) into a single-entry output buffer handshaked with
// the downstream shifter/ALU stage.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [REG_AW-1:0] rd_num_a,
  input  logic [REG_AW-1:0] rd_num_b,
  input  logic [1:0]        shift_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);

  logic [DATA_W-1:0] rfDataA;
  logic [DATA_W-1:0] rfDataB;
  logic [DATA_W-1:0] operandA;
  logic [DATA_W-1:0] operandB;
  logic              accept;

  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] aOut_q, aOut_d;
  logic [DATA_W-1:0] bOut_q, bOut_d;
  logic [1:0]        shiftOut_q, shiftOut_d;

  operand_fetch_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_en),
    .wr_num_i    (wr_num),
    .wr_data_i   (wr_data),
    .rd_num_a_i  (rd_num_a),
    .rd_num_b_i  (rd_num_b),
    .rd_data_a_o (rfDataA),
    .rd_data_b_o (rfDataB)
  );

  // The buffer can take a new pair when empty or when its pair leaves this edge
  assign rd_ready = !outValid_q || out_ready;
  assign accept   = rd_valid && rd_ready;

  // Forward write data when the read hits the register being written this edge
  assign operandA = (wr_en && (wr_num == rd_num_a)) ? wr_data : rfDataA;
  assign operandB = (wr_en && (wr_num == rd_num_b)) ? wr_data : rfDataB;

  // Next buffer state: load on accept, drain on consume, otherwise hold
  always_comb begin
    outValid_d = outValid_q;
    aOut_d     = aOut_q;
    bOut_d     = bOut_q;
    shiftOut_d = shiftOut_q;
    if (accept) begin
      outValid_d = 1'b1;
      aOut_d     = operandA;
      bOut_d     = operandB;
      shiftOut_d = shift_in;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Output buffer registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      aOut_q     <= '0;
      bOut_q     <= '0;
      shiftOut_q <= 2'b00;
    end else begin
      outValid_q <= outValid_d;
      aOut_q     <= aOut_d;
      bOut_q     <= bOut_d;
      shiftOut_q <= shiftOut_d;
    end
  end

  assign out_valid = outValid_q;
  assign a_out     = aOut_q;
  assign b_out     = bOut_q;
  assign shift_out = shiftOut_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: the stimulus side pushes expected pairs
// on accepted fetches, a monitor compares the presented pair every cycle.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_num;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  rd_num_a;
  logic [2:0]  rd_num_b;
  logic [1:0]  shift_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a_out;
  logic [15:0] b_out;
  logic [1:0]  shift_out;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sh;
  } pair_t;

  pair_t       sb[$];
  logic [15:0] mRegs [8];
  logic        mValid;
  int          testsRun;
  int          testsFailed;

  operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_num    (wr_num),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_num_a  (rd_num_a),
    .rd_num_b  (rd_num_b),
    .shift_in  (shift_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .shift_out (shift_out)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so a stuck run still ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, entered and left 1 unit after a rising edge
  task automatic applyStimulus(
    input logic        we,
    input logic [2:0]  wn,
    input logic [15:0] wd,
    input logic        rv,
    input logic [2:0]  na,
    input logic [2:0]  nb,
    input logic [1:0]  sh,
    input logic        ordy
  );
    logic  acc;
    pair_t p;
    wr_en     = we;
    wr_num    = wn;
    wr_data   = wd;
    rd_valid  = rv;
    rd_num_a  = na;
    rd_num_b  = nb;
    shift_in  = sh;
    out_ready = ordy;
    #1;
    checkOutput("rd_ready", {31'b0, rd_ready}, {31'b0, (!mValid || ordy)});
    acc = rv && (!mValid || ordy);
    if (acc) begin
      p.a  = (we && wn == na) ? wd : mRegs[na];
      p.b  = (we && wn == nb) ? wd : mRegs[nb];
      p.sh = sh;
      sb.push_back(p);
    end
    if (we) mRegs[wn] = wd;
    if (acc) mValid = 1'b1;
    else if (ordy) mValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, mValid});
  endtask

  task automatic idleCycle(input logic ordy);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 2'b00, ordy);
  endtask

  // Monitor: compare every presented pair with the scoreboard head, pop on consume
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'd1, 32'd0);
        end else begin
          checkOutput("a_out", {16'b0, a_out}, {16'b0, sb[0].a});
          checkOutput("b_out", {16'b0, b_out}, {16'b0, sb[0].b});
          checkOutput("shift_out", {30'b0, shift_out}, {30'b0, sb[0].sh});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    mValid      = 1'b0;
    for (int i = 0; i < 8; i++) mRegs[i] = 16'h0000;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_num    = 3'd0;
    wr_data   = 16'h0;
    rd_valid  = 1'b0;
    rd_num_a  = 3'd0;
    rd_num_b  = 3'd0;
    shift_in  = 2'b00;
    out_ready = 1'b0;
    #3;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_a_out", {16'b0, a_out}, 32'd0);
    checkOutput("reset_b_out", {16'b0, b_out}, 32'd0);
    checkOutput("reset_shift_out", {30'b0, shift_out}, 32'd0);
    checkOutput("reset_rd_ready", {31'b0, rd_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic fetch of two written registers
    applyStimulus(1'b1, 3'd3, 16'h82C5, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1);
    applyStimulus(1'b1, 3'd5, 16'h0001, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1);
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 2'b01, 1'b1);
    idleCycle(1'b1);

    // Same-edge write bypass into both operands
    applyStimulus(1'b1, 3'd2, 16'hBEEF, 1'b1, 3'd2, 3'd2, 2'b00, 1'b1);
    idleCycle(1'b1);

    // Backpressure: hold for 3 cycles while writes continue, then replace
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd3, 16'h1234, 1'b1, 3'd2, 3'd3, 2'b00, 1'b0);
    end
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd2, 2'b11, 1'b1);
    idleCycle(1'b1);

    // Back-to-back fetches, each bypassing a fresh write to r1
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'd1, 16'h00A0 + 16'(i), 1'b1, 3'd1, 3'(i + 2), 2'(i), 1'b1);
    end
    idleCycle(1'b1);

    // Arithmetic right shift of the captured operand B
    applyStimulus(1'b1, 3'd3, 16'h82C5, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1);
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd3, 2'b11, 1'b0);
    checkOutput("shifter_asr", {16'b0, shiftApply(b_out, shift_out)}, {16'b0, 16'hC162});

    // Reset while a pair is held, with a write and fetch on an edge during reset
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midreset_a_out", {16'b0, a_out}, 32'd0);
    checkOutput("midreset_b_out", {16'b0, b_out}, 32'd0);
    sb.delete();
    mValid = 1'b0;
    for (int i = 0; i < 8; i++) mRegs[i] = 16'h0000;
    wr_en    = 1'b1;
    wr_num   = 3'd3;
    wr_data  = 16'hFFFF;
    rd_valid = 1'b1;
    rd_num_a = 3'd3;
    rd_num_b = 3'd3;
    @(posedge clk);
    #1;
    checkOutput("inreset_out_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd3, 2'b00, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
